frame_fas_sync: RTL



---
 rtl/frame_fas_sync.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/frame_fas_sync.sv
// Receive-side frame synchroniser: hunts for the FAS in a valid-qualified word stream,
// confirms it over consecutive frames, and then regenerates start-of-frame.
// Define FRAME_FAS_SYNC_ERR_COUNT_EN to build the saturating FAS-miss counter on o_fas_err_count.
module frame_fas_sync #(
    parameter int NB_DATA       = 256,
    parameter int NB_FRAME_SIZE = 16,
    parameter int NB_FAS        = 48,
    parameter int N_CONFIRM     = 2,
    parameter int N_LOSS        = 3,
    parameter int NB_ERR_CNT    = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NB_DATA-1:0]       i_data,
    input  logic                     i_valid,
    input  logic [NB_FRAME_SIZE-1:0] i_frame_size,
    input  logic [NB_FAS-1:0]        i_fas,
    output logic [NB_DATA-1:0]       o_data,
    output logic                     o_valid,
    output logic                     o_sof,
    output logic                     o_lock,
    output logic [NB_ERR_CNT-1:0]    o_fas_err_count
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PRESYNC = 2'd1;
    localparam logic [1:0] ST_SYNC    = 2'd2;

    localparam int NB_HITS = $clog2(N_CONFIRM + 1);
    localparam int NB_MISS = $clog2(N_LOSS + 1);

    localparam logic [NB_FRAME_SIZE-1:0] WCNT_ZERO = NB_FRAME_SIZE'(1'b0);
    localparam logic [NB_FRAME_SIZE-1:0] WCNT_ONE  = NB_FRAME_SIZE'(1'b1);
    localparam logic [NB_HITS-1:0]       HITS_ZERO = NB_HITS'(1'b0);
    localparam logic [NB_HITS-1:0]       HITS_ONE  = NB_HITS'(1'b1);
    localparam logic [NB_HITS-1:0]       HITS_LAST = NB_HITS'(N_CONFIRM - 1);
    localparam logic [NB_MISS-1:0]       MISS_ZERO = NB_MISS'(1'b0);
    localparam logic [NB_MISS-1:0]       MISS_ONE  = NB_MISS'(1'b1);
    localparam logic [NB_MISS-1:0]       MISS_LAST = NB_MISS'(N_LOSS - 1);

    logic [1:0]               state_q, state_d;
    logic [NB_FRAME_SIZE-1:0] wcnt_q, wcnt_d;
    logic [NB_HITS-1:0]       hits_q, hits_d;
    logic [NB_MISS-1:0]       miss_q, miss_d;
    logic [NB_DATA-1:0]       data_q;
    logic                     valid_q;
    logic                     sof_q, sof_d;
    logic                     lock_q;

    logic                     match_s;
    logic                     slot_s;
    logic [NB_FRAME_SIZE-1:0] wcnt_next_s;
    logic                     cnt_inc_s;

    assign match_s     = (i_data[NB_DATA-1 -: NB_FAS] == i_fas);
    assign slot_s      = (wcnt_q == WCNT_ZERO);
    assign wcnt_next_s = (wcnt_q == (i_frame_size - WCNT_ONE)) ? WCNT_ZERO : (wcnt_q + WCNT_ONE);

    // Next-state logic: HUNT ignores the word counter, PRESYNC/SYNC only judge slot words.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        hits_d    = hits_q;
        miss_d    = miss_q;
        sof_d     = 1'b0;
        cnt_inc_s = 1'b0;
        if (i_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (match_s) begin
                        wcnt_d = WCNT_ONE;
                        hits_d = HITS_ONE;
                        if (N_CONFIRM == 1) begin
                            state_d = ST_SYNC;
                            sof_d   = 1'b1;
                        end else begin
                            state_d = ST_PRESYNC;
                        end
                    end else begin
                        wcnt_d = WCNT_ZERO;
                    end
                end
                ST_PRESYNC: begin
                    wcnt_d = wcnt_next_s;
                    if (slot_s) begin
                        if (match_s) begin
                            if (hits_q == HITS_LAST) begin
                                state_d = ST_SYNC;
                                hits_d  = HITS_ZERO;
                                sof_d   = 1'b1;
                            end else begin
                                hits_d = hits_q + HITS_ONE;
                            end
                        end else begin
                            // The failing word is not retried as a fresh candidate.
                            state_d = ST_HUNT;
                            hits_d  = HITS_ZERO;
                            wcnt_d  = WCNT_ZERO;
                        end
                    end else begin
                        sof_d = 1'b0;
                    end
                end
                ST_SYNC: begin
                    wcnt_d = wcnt_next_s;
                    if (slot_s) begin
                        if (match_s) begin
                            miss_d = MISS_ZERO;
                            sof_d  = 1'b1;
                        end else begin
                            cnt_inc_s = 1'b1;
                            if (miss_q == MISS_LAST) begin
                                state_d = ST_HUNT;
                                miss_d  = MISS_ZERO;
                                wcnt_d  = WCNT_ZERO;
                            end else begin
                                // Flywheel: a tolerated miss still marks the frame boundary.
                                miss_d = miss_q + MISS_ONE;
                                sof_d  = 1'b1;
                            end
                        end
                    end else begin
                        sof_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    wcnt_d  = WCNT_ZERO;
                    hits_d  = HITS_ZERO;
                    miss_d  = MISS_ZERO;
                end
            endcase
        end else begin
            sof_d = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_HUNT;
            wcnt_q  <= WCNT_ZERO;
            hits_q  <= HITS_ZERO;
            miss_q  <= MISS_ZERO;
            data_q  <= {NB_DATA{1'b0}};
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            data_q  <= i_data;
            valid_q <= i_valid;
            sof_q   <= sof_d;
            lock_q  <= (state_d == ST_SYNC);
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_sof   = sof_q;
    assign o_lock  = lock_q;

`ifdef FRAME_FAS_SYNC_ERR_COUNT_EN
    localparam logic [NB_ERR_CNT-1:0] ERR_MAX = {NB_ERR_CNT{1'b1}};
    localparam logic [NB_ERR_CNT-1:0] ERR_ONE = NB_ERR_CNT'(1'b1);

    logic [NB_ERR_CNT-1:0] err_cnt_q, err_cnt_d;

    // Saturating miss counter: sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_inc_s && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Miss counter register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            err_cnt_q <= {NB_ERR_CNT{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_fas_err_count = err_cnt_q;
`else
    logic unused_cnt_inc_s;
    assign unused_cnt_inc_s = cnt_inc_s;
    assign o_fas_err_count  = {NB_ERR_CNT{1'b0}};
`endif

endmodule
